alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, plus new shifts SLL, SRL, SRA.
- New multi-cycle ops: MUL, MULHU, DIVU, REMU, executed iteratively behind a valid/ready handshake.
- Sits in the execute stage of the multi-cycle core; the controller stalls on in_ready low.

---
 rtl/alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready request interface.
// Single-cycle ops (ADD..SRA) complete one edge after acceptance.
// Define ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU unit
// (shift-add multiply, restoring divide, one step per clock). Without it,
// opcodes 10-13 are reported as illegal and in_ready is constant 1.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Opc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] w,
  output logic             Zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
`endif

  // Registered outputs
  logic [WIDTH-1:0] w_reg, w_next;
  logic             zero_reg, zero_next;
  logic             illegal_reg, illegal_next;
  logic             out_valid_reg, out_valid_next;

  // Single-cycle result for the opcode currently on the inputs
  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;

  // Combinational single-cycle datapath; unsupported codes flag illegal
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (Opc)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
`ifdef ALU_MULDIV_EN
      // Handled by the iterative unit; the value here is never used.
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
`endif
      default: begin
        alu_res     = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  // hi/lo form the 2*WIDTH working register: partial product for MUL,
  // {remainder, dividend/quotient} for DIV.
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  // Multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] opnd_reg, opnd_next;
  logic             op_div_reg, op_div_next;
  logic             op_hi_reg, op_hi_next;

  logic             is_multi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign is_multi = (Opc == OP_MUL) || (Opc == OP_MULHU) ||
                    (Opc == OP_DIVU) || (Opc == OP_REMU);

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_diff  = div_shift - {1'b0, opnd_reg};
    // With a zero divisor every step subtracts nothing: quotient becomes
    // all ones and the remainder ends up equal to the dividend.
    div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo_reg[WIDTH-2:0], div_ge};
    step_hi   = op_div_reg ? div_hi : mul_hi;
    step_lo   = op_div_reg ? div_lo : mul_lo;
  end

  assign in_ready = (state_reg == IDLE);
`else
  assign in_ready = 1'b1;
`endif

  // Next-state and output logic for request acceptance and completion
  always_comb begin
    w_next         = w_reg;
    zero_next      = zero_reg;
    illegal_next   = illegal_reg;
    out_valid_next = 1'b0;
`ifdef ALU_MULDIV_EN
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    opnd_next      = opnd_reg;
    op_div_next    = op_div_reg;
    op_hi_next     = op_hi_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_multi) begin
            state_next  = RUN;
            cnt_next    = SHW'(WIDTH - 1);
            op_div_next = Opc[2];
            op_hi_next  = Opc[0];
            hi_next     = '0;
            if (Opc[2]) begin
              opnd_next = b;
              lo_next   = a;
            end else begin
              opnd_next = a;
              lo_next   = b;
            end
          end else begin
            w_next         = alu_res;
            zero_next      = ~|alu_res;
            illegal_next   = alu_illegal;
            out_valid_next = 1'b1;
          end
        end
      end
      RUN: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next     = IDLE;
          cnt_next       = '0;
          w_next         = op_hi_reg ? step_hi : step_lo;
          zero_next      = ~|(op_hi_reg ? step_hi : step_lo);
          illegal_next   = 1'b0;
          out_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
`else
    if (in_valid) begin
      w_next         = alu_res;
      zero_next      = ~|alu_res;
      illegal_next   = alu_illegal;
      out_valid_next = 1'b1;
    end
`endif
  end

  // Output registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg         <= '0;
      zero_reg      <= 1'b1;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      w_reg         <= w_next;
      zero_reg      <= zero_next;
      illegal_reg   <= illegal_next;
      out_valid_reg <= out_valid_next;
    end
  end

`ifdef ALU_MULDIV_EN
  // FSM state, iteration counter and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      op_div_reg <= 1'b0;
      op_hi_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opnd_reg   <= opnd_next;
      op_div_reg <= op_div_next;
      op_hi_reg  <= op_hi_next;
    end
  end
`endif

  assign w         = w_reg;
  assign Zero      = zero_reg;
  assign illegal   = illegal_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32). Expected results are
// queued when a request is driven and checked when out_valid is seen.
// Multi-cycle tests are built only when ALU_MULDIV_EN is defined.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Opc;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] w;
  logic        Zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        z;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Opc(Opc), .a(a), .b(b), .out_valid(out_valid), .w(w),
    .Zero(Zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference model
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    logic [31:0] r;
    logic ill;
    r = 32'd0;
    ill = 1'b0;
    p = {32'd0, x} * {32'd0, y};
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << y[4:0];
      4'd8: r = x >> y[4:0];
      4'd9: r = $unsigned($signed(x) >>> y[4:0]);
`ifdef ALU_MULDIV_EN
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd13: r = (y == 0) ? x : x % y;
`endif
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    e.w = r;
    e.z = (r == 32'd0);
    e.ill = ill;
    return e;
  endfunction

  // Scoreboard monitor: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid got w=%h z=%b ill=%b expected none", w, Zero, illegal);
      end else begin
        e = sb.pop_front();
        if ({w, Zero, illegal} !== {e.w, e.z, e.ill}) begin
          bad++;
          $display("FAIL result got w=%h z=%b ill=%b expected w=%h z=%b ill=%b",
                   w, Zero, illegal, e.w, e.z, e.ill);
        end else begin
          $display("txn w=%h z=%b ill=%b", w, Zero, illegal);
        end
      end
    end
  end

  // Drive one request for one edge; called and returns at a negedge
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    Opc = op; a = x; b = y; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; Opc = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, in_ready, w, Zero, illegal} !== {1'b0, 1'b1, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got ov=%b rdy=%b w=%h z=%b ill=%b expected ov=0 rdy=1 w=0 z=1 ill=0",
               out_valid, in_ready, w, Zero, illegal);
    end
    rst = 1'b0;
    @(negedge clk);
    send(4'd0, 32'hFFFF_FFFF, 32'd1, '{w: 32'd0, z: 1'b1, ill: 1'b0});
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width got out_valid=%b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready0 got %b expected 1", in_ready);
    end
    send(4'd5, 32'hFFFF_FFFE, 32'd1, '{w: 32'd1, z: 1'b0, ill: 1'b0});
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready1 got %b expected 1", in_ready);
    end
    send(4'd9, 32'h8000_0000, 32'd4, '{w: 32'hF800_0000, z: 1'b0, ill: 1'b0});
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready2 got %b expected 1", in_ready);
    end
    drain();
  endtask

  task automatic test_illegal();
    send(4'd15, 32'd5, 32'd5, '{w: 32'd0, z: 1'b1, ill: 1'b1});
    send(4'd0, 32'd1, 32'd1, '{w: 32'd2, z: 1'b0, ill: 1'b0});
    send(4'd14, 32'd9, 32'd3, '{w: 32'd0, z: 1'b1, ill: 1'b1});
`ifndef ALU_MULDIV_EN
    for (int op = 10; op <= 13; op++) begin
      send(4'(op), 32'd7, 32'd3, '{w: 32'd0, z: 1'b1, ill: 1'b1});
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL illegal_ready op=%0d got %b expected 1", op, in_ready);
      end
    end
`endif
    drain();
  endtask

  task automatic test_random_single();
    logic [3:0] op;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
`ifdef ALU_MULDIV_EN
      op = 4'($urandom_range(0, 11));
      if (op >= 4'd10) op = op + 4'd4;
`else
      op = 4'($urandom_range(0, 15));
`endif
      x = $urandom();
      y = (i % 4 == 0) ? x : $urandom();
      send(op, x, y, model(op, x, y));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(4'd0, 32'd1, 32'd2, '{w: 32'd3, z: 1'b0, ill: 1'b0});
    drain();
    // Reset coinciding with a request: reset wins
    Opc = 4'd15; a = 32'd1; b = 32'd1; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    total++;
    if ({out_valid, w, Zero, illegal} !== {1'b0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_wins got ov=%b w=%h z=%b ill=%b expected ov=0 w=0 z=1 ill=0",
               out_valid, w, Zero, illegal);
    end
    send(4'd15, 32'd1, 32'd1, '{w: 32'd0, z: 1'b1, ill: 1'b1});
    drain();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_illegal got %b expected 0", illegal);
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_mul_latency();
    int cnt = 0;
    send(4'd10, 32'h0001_0001, 32'h0001_0001, '{w: 32'h0002_0001, z: 1'b0, ill: 1'b0});
    while (in_ready === 1'b0 && cnt < 100) begin
      cnt++;
      if (cnt < 10) begin
        Opc = 4'd0; a = 32'd4; b = 32'd4; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (cnt != 32) begin
      bad++;
      $display("FAIL mul_busy_cycles got %0d expected 32", cnt);
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mul_done got out_valid=%b expected 1", out_valid);
    end
    drain();
    send(4'd11, 32'h0001_0001, 32'h0001_0001, '{w: 32'h0000_0001, z: 1'b0, ill: 1'b0});
    wait_ready();
    drain();
  endtask

  task automatic test_divide();
    logic [3:0]  ops [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [31:0] xs  [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] ys  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] rs  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], xs[i], ys[i], '{w: rs[i], z: 1'b0, ill: 1'b0});
      wait_ready();
      drain();
    end
  endtask

  task automatic test_random_multi();
    logic [3:0] op;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(10, 13));
      x = $urandom();
      y = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      send(op, x, y, model(op, x, y));
      wait_ready();
      drain();
    end
  endtask

  task automatic test_reset_run();
    send(4'd0, 32'd10, 32'd20, '{w: 32'd30, z: 1'b0, ill: 1'b0});
    drain();
    send(4'd12, 32'd100, 32'd7, '{w: 32'd14, z: 1'b0, ill: 1'b0});
    repeat (9) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, w, Zero} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_run got ov=%b rdy=%b w=%h z=%b expected ov=0 rdy=1 w=0 z=1",
               out_valid, in_ready, w, Zero);
    end
    // Any stray completion of the abandoned divide is reported by the monitor
    repeat (40) @(negedge clk);
    send(4'd0, 32'd2, 32'd3, '{w: 32'd5, z: 1'b0, ill: 1'b0});
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_illegal();
    test_random_single();
    test_reset_mid();
`ifdef ALU_MULDIV_EN
    test_mul_latency();
    test_divide();
    test_random_multi();
    test_reset_run();
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
